uart_axislave_v2: RTL
=====================

UART_AXISLAVE_V2 -- requirements
Module: uart_axislave_v2

Interface
REQ-001 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, AXI data width; only 32 is supported.
REQ-002 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 5, AXI byte address width; must be at least 5.
REQ-003 SHALL have parameter PRESCALER_WIDTH, default 16, prescaler field width; legal range 8..24.
REQ-004 SHALL have parameter DEFAULT_PRESCALER, default 25, prescaler reset value.
REQ-005 SHALL have parameter MAX_DATA_BITS, default 8, widest character; legal range 8..9.
REQ-006 SHALL have port S_AXI_ACLK, in, 1, the single clock.
REQ-007 SHALL have port S_AXI_ARESETN, in, 1, reset; asynchronous, active-low.
REQ-008 SHALL have the AXI4-Lite slave ports S_AXI_AW*/W*/B*/AR*/R*, with the standard directions and widths; AWPROT/ARPROT are ignored.
REQ-009 SHALL have the config outputs PR_DIV [PRESCALER_WIDTH], STOP_BITS [1], PARITY [3] and DATA_BITS [4], all driven from registers.
REQ-010 SHALL have the status inputs TXB, RXB, RXE and TXF (1 bit each), plus the 1-bit event pulses RX_OVR and RX_PERR.
REQ-011 SHALL have the TX stream outputs TX_TDATA [MAX_DATA_BITS] and TX_TVALID, and the input TX_TREADY.
REQ-012 SHALL have the RX stream inputs RX_TDATA [MAX_DATA_BITS] and RX_TVALID, and the output RX_TREADY.
REQ-013 SHALL have output IRQ, 1 bit, level, registered.

Function
REQ-014 SHALL decode word index ADDR[4:2]:
- 0: PRESCALER, RW.
- 1: FORMAT, RW; [0] stop bits, [3:1] parity, [7:4] data bits.
- 2: STATUS, RO; {TXF, RXE, RXB, TXB} in bits [3:0].
- 3: IRQ_EN, RW, [3:0].
- 4: IRQ_STATUS, W1C, [3:0].
- 5: TXDATA, WO.
- 6: RXDATA, RO.
- 7: reserved; reads 0, writes ignored, response OKAY.
- Unused bits read 0.
REQ-015 SHALL accept a write only when AWVALID, WVALID and !BVALID are all high: AWREADY and WREADY pulse high together for exactly one cycle, the register updates on that cycle, and BVALID rises on the next cycle and holds until BREADY.
REQ-016 SHALL accept a read when ARVALID, !ARREADY and !RVALID are all high: ARREADY pulses for one cycle; RDATA/RRESP are registered and RVALID rises on the next cycle and holds until RREADY.
REQ-017 SHALL apply WSTRB per byte to RW registers; a W1C register clears only bits that are 1 within enabled byte lanes.
REQ-018 SHALL ignore a FORMAT data-bits write of a value outside 5..MAX_DATA_BITS, so that the field keeps its old value, while the other FORMAT fields still update.
REQ-019 SHALL, on a TXDATA write while TX_TVALID=0, load TX_TDATA=WDATA[MAX_DATA_BITS-1:0] and set TX_TVALID on the next cycle, with BRESP=OKAY.
REQ-020 SHALL, on a TXDATA write while TX_TVALID=1, drop the data, leave TX_TDATA unchanged and return BRESP=SLVERR (2'b10).
REQ-021 SHALL clear TX_TVALID on the cycle after TX_TVALID&TX_TREADY; TX_TDATA is held stable while TX_TVALID=1.
REQ-022 SHALL, on an RXDATA read accepted with RX_TVALID=1, capture RX_TDATA into RDATA with RRESP=OKAY and assert RX_TREADY for exactly that one cycle.
REQ-023 SHALL, on an RXDATA read with RX_TVALID=0, return RDATA=0 and RRESP=SLVERR, with no RX_TREADY pulse.
REQ-024 SHALL set each IRQ_STATUS bit sticky on its event:
- bit0 on a TXB 1->0 edge;
- bit1 on an RXE 1->0 edge;
- bit2 on RX_OVR;
- bit3 on RX_PERR.
- Edges are detected with registered previous values.
REQ-025 SHALL give set priority when a set event and a W1C clear of the same bit occur in the same cycle.
REQ-026 SHALL drive IRQ as a register equal to |(IRQ_STATUS & IRQ_EN), one cycle after either operand changes.
REQ-027 SHALL never accept a read and a write in the same cycle; the channels are independent, and a simultaneous AW/W and AR are each accepted per REQ-015/REQ-016.

Reset
REQ-028 SHALL, on S_AXI_ARESETN=0 and asynchronously, reset all of the following: every READY/VALID output to 0, BRESP/RRESP/RDATA to 0, PRESCALER to DEFAULT_PRESCALER, FORMAT to stop bits 0, parity 0 and data bits 8, IRQ_EN and IRQ_STATUS to 0, TX_TDATA to 0, the edge-detect registers to 0, and IRQ to 0.
REQ-029 SHALL drop any in-flight transaction when reset asserts mid-transaction, with no response issued after reset deasserts.

Configuration
REQ-030 SHALL, when macro UART_AXISLAVE_IRQ_EN is defined, implement IRQ_EN, IRQ_STATUS and IRQ per REQ-024..REQ-026.
REQ-031 SHALL, when UART_AXISLAVE_IRQ_EN is undefined, read indices 3 and 4 as 0, ignore writes to them with OKAY, hold IRQ at 0, and keep all ports present.

Verification
REQ-032 SHALL be covered by a reset scenario: reset, then read index 0 -> RDATA=25, RRESP=OKAY; then read index 1 -> RDATA=0x80.
REQ-033 SHALL be covered by a TX scenario: write TXDATA 0x41 with TX_TREADY=0 -> TX_TVALID=1, TX_TDATA=0x41; write TXDATA 0x42 -> BRESP=SLVERR and TX_TDATA stays 0x41; raise TX_TREADY -> TX_TVALID=0 on the next cycle.
REQ-034 SHALL be covered by an RX scenario: with RX_TVALID=1 and RX_TDATA=0x5A, read index 6 -> RDATA=0x5A, a single-cycle RX_TREADY pulse, RRESP=OKAY; with RX_TVALID=0, read index 6 -> RDATA=0, RRESP=SLVERR.
REQ-035 SHALL be covered by a strobe/format scenario: write FORMAT 0xC3 -> data bits stay 8, stop bits=1, parity=1; write PRESCALER 0x1234 with WSTRB=0001 -> PR_DIV=0x0034 (from 25).
REQ-036 SHALL be covered by an IRQ scenario (macro defined): write IRQ_EN=0x4, pulse RX_OVR -> IRQ=1; write IRQ_STATUS=0x4 in the same cycle as a second RX_OVR pulse -> bit2 stays set; write IRQ_STATUS=0x4 again -> IRQ=0.
REQ-037 SHALL be covered by an async-reset scenario: assert reset while BVALID=1 -> BVALID=0 immediately; after reset deasserts, no BVALID appears.

Source files
------------

// File: rtl/uart_axislave_v2.sv
// AXI4-Lite register front end for a UART core: config, status, TX/RX streams.
// Define UART_AXISLAVE_IRQ_EN to build the IRQ_EN/IRQ_STATUS interrupt logic.
module uart_axislave_v2 #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5,
    parameter int PRESCALER_WIDTH    = 16,
    parameter int DEFAULT_PRESCALER  = 25,
    parameter int MAX_DATA_BITS      = 8
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic [PRESCALER_WIDTH-1:0]      PR_DIV,
    output logic                            STOP_BITS,
    output logic [2:0]                      PARITY,
    output logic [3:0]                      DATA_BITS,
    input  logic                            TXB,
    input  logic                            RXB,
    input  logic                            RXE,
    input  logic                            TXF,
    input  logic                            RX_OVR,
    input  logic                            RX_PERR,
    output logic [MAX_DATA_BITS-1:0]        TX_TDATA,
    output logic                            TX_TVALID,
    input  logic                            TX_TREADY,
    input  logic [MAX_DATA_BITS-1:0]        RX_TDATA,
    input  logic                            RX_TVALID,
    output logic                            RX_TREADY,
    output logic                            IRQ
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic                          aw_ready_q;
    logic                          wr_start;
    logic                          rd_start;
    logic [2:0]                    wr_idx;
    logic [2:0]                    rd_idx;
    logic [PRESCALER_WIDTH-1:0]    prescaler;
    logic [PRESCALER_WIDTH-1:0]    pr_next;
    logic                          stop_q;
    logic [2:0]                    parity_q;
    logic [3:0]                    dbits_q;
    logic [C_S_AXI_DATA_WIDTH-1:0] rd_word;
    logic [1:0]                    rd_resp;
    logic [3:0]                    irq_en_rd;
    logic [3:0]                    irq_st_rd;
    logic                          unused_inputs;

    assign wr_idx = S_AXI_AWADDR[4:2];
    assign rd_idx = S_AXI_ARADDR[4:2];

    // A write start wins over a read start so both never handshake together.
    assign wr_start = S_AXI_AWVALID & S_AXI_WVALID & ~S_AXI_BVALID & ~aw_ready_q;
    assign rd_start = S_AXI_ARVALID & ~S_AXI_ARREADY & ~S_AXI_RVALID
                    & ~wr_start & ~aw_ready_q;

    assign S_AXI_AWREADY = aw_ready_q;
    assign S_AXI_WREADY  = aw_ready_q;

    assign PR_DIV    = prescaler;
    assign STOP_BITS = stop_q;
    assign PARITY    = parity_q;
    assign DATA_BITS = dbits_q;

    assign RX_TREADY = S_AXI_ARREADY & (rd_idx == 3'd6) & RX_TVALID;

    assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR,
                             S_AXI_ARADDR, S_AXI_WDATA, S_AXI_WSTRB,
                             RX_OVR, RX_PERR};

    always_comb begin
        pr_next = prescaler;
        for (int i = 0; i < PRESCALER_WIDTH; i++) begin
            if (S_AXI_WSTRB[i/8]) pr_next[i] = S_AXI_WDATA[i];
        end
    end

    always_comb begin
        rd_word = '0;
        rd_resp = RESP_OKAY;
        case (rd_idx)
            3'd0: rd_word[PRESCALER_WIDTH-1:0] = prescaler;
            3'd1: rd_word[7:0] = {dbits_q, parity_q, stop_q};
            3'd2: rd_word[3:0] = {TXF, RXE, RXB, TXB};
            3'd3: rd_word[3:0] = irq_en_rd;
            3'd4: rd_word[3:0] = irq_st_rd;
            3'd6: begin
                if (RX_TVALID) rd_word[MAX_DATA_BITS-1:0] = RX_TDATA;
                else           rd_resp = RESP_SLVERR;
            end
            default: ;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            aw_ready_q    <= 1'b0;
            S_AXI_ARREADY <= 1'b0;
            S_AXI_BVALID  <= 1'b0;
            S_AXI_BRESP   <= RESP_OKAY;
            S_AXI_RVALID  <= 1'b0;
            S_AXI_RRESP   <= RESP_OKAY;
            S_AXI_RDATA   <= '0;
            prescaler     <= PRESCALER_WIDTH'(DEFAULT_PRESCALER);
            stop_q        <= 1'b0;
            parity_q      <= 3'd0;
            dbits_q       <= 4'd8;
            TX_TDATA      <= '0;
            TX_TVALID     <= 1'b0;
        end else begin
            aw_ready_q    <= wr_start;
            S_AXI_ARREADY <= rd_start;
            if (S_AXI_BVALID && S_AXI_BREADY) S_AXI_BVALID <= 1'b0;
            if (S_AXI_RVALID && S_AXI_RREADY) S_AXI_RVALID <= 1'b0;
            if (TX_TVALID && TX_TREADY) TX_TVALID <= 1'b0;
            if (S_AXI_ARREADY) begin
                S_AXI_RVALID <= 1'b1;
                S_AXI_RDATA  <= rd_word;
                S_AXI_RRESP  <= rd_resp;
            end
            if (aw_ready_q) begin
                S_AXI_BVALID <= 1'b1;
                S_AXI_BRESP  <= RESP_OKAY;
                case (wr_idx)
                    3'd0: prescaler <= pr_next;
                    3'd1: begin
                        if (S_AXI_WSTRB[0]) begin
                            stop_q   <= S_AXI_WDATA[0];
                            parity_q <= S_AXI_WDATA[3:1];
                            if (S_AXI_WDATA[7:4] >= 4'd5 &&
                                S_AXI_WDATA[7:4] <= 4'(MAX_DATA_BITS))
                                dbits_q <= S_AXI_WDATA[7:4];
                        end
                    end
                    3'd5: begin
                        // A character still waiting to be taken is never overwritten.
                        if (!TX_TVALID) begin
                            TX_TDATA  <= S_AXI_WDATA[MAX_DATA_BITS-1:0];
                            TX_TVALID <= 1'b1;
                        end else begin
                            S_AXI_BRESP <= RESP_SLVERR;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef UART_AXISLAVE_IRQ_EN
    logic [3:0] irq_en;
    logic [3:0] irq_st;
    logic [3:0] irq_set;
    logic [3:0] irq_clr;
    logic       txb_q;
    logic       rxe_q;

    assign irq_en_rd = irq_en;
    assign irq_st_rd = irq_st;
    assign irq_set   = {RX_PERR, RX_OVR, rxe_q & ~RXE, txb_q & ~TXB};
    assign irq_clr   = (aw_ready_q && wr_idx == 3'd4 && S_AXI_WSTRB[0])
                     ? S_AXI_WDATA[3:0] : 4'd0;

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            irq_en <= 4'd0;
            irq_st <= 4'd0;
            txb_q  <= 1'b0;
            rxe_q  <= 1'b0;
            IRQ    <= 1'b0;
        end else begin
            txb_q <= TXB;
            rxe_q <= RXE;
            if (aw_ready_q && wr_idx == 3'd3 && S_AXI_WSTRB[0])
                irq_en <= S_AXI_WDATA[3:0];
            // New events override a same-cycle clear.
            irq_st <= (irq_st & ~irq_clr) | irq_set;
            IRQ    <= |(irq_st & irq_en);
        end
    end
`else
    assign irq_en_rd = 4'd0;
    assign irq_st_rd = 4'd0;
    assign IRQ       = 1'b0;
`endif

endmodule
